// File: rtl/gameconsole_pkg.sv
// Shared video RAM map, region decode and shadow FIFO payload for the CPU memory port.
package gameconsole_pkg;

  localparam int unsigned VRAM_OFS_W  = 17;
  localparam int unsigned VRAM_DATA_W = 32;
  localparam int unsigned VRAM_NREG   = 4;

  localparam logic [31:0] REG_PARAM_BASE  = 32'h0600_0000;
  localparam logic [31:0] REG_PARAM_WORDS = 32'h0000_0400;
  localparam logic [31:0] REG_MAP_BASE    = 32'h0610_0000;
  localparam logic [31:0] REG_MAP_WORDS   = 32'h0000_0800;
  localparam logic [31:0] REG_TILE_BASE   = 32'h0620_0000;
  localparam logic [31:0] REG_TILE_WORDS  = 32'h0002_0000;
  localparam logic [31:0] REG_PAL_BASE    = 32'h0630_0000;
  localparam logic [31:0] REG_PAL_WORDS   = 32'h0000_0200;

  typedef enum logic [2:0] {
    VR_PARAM = 3'd0,
    VR_MAP   = 3'd1,
    VR_TILE  = 3'd2,
    VR_PAL   = 3'd3,
    VR_NONE  = 3'd4
  } vram_region_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } shadow_state_e;

  typedef struct packed {
    logic [VRAM_OFS_W-1:0]  ofs;
    logic [VRAM_DATA_W-1:0] data;
  } shadow_entry_t;

  // Address to region; the unsigned subtract also rejects addresses below each base.
  function automatic vram_region_e vram_decode(input logic [31:0] addr);
    vram_region_e r;
    r = VR_NONE;
    if ((addr - REG_PARAM_BASE) < REG_PARAM_WORDS)     r = VR_PARAM;
    else if ((addr - REG_MAP_BASE) < REG_MAP_WORDS)    r = VR_MAP;
    else if ((addr - REG_TILE_BASE) < REG_TILE_WORDS)  r = VR_TILE;
    else if ((addr - REG_PAL_BASE) < REG_PAL_WORDS)    r = VR_PAL;
    return r;
  endfunction

  // Base word address of a region (0 for unmapped).
  function automatic logic [31:0] vram_base(input vram_region_e r);
    logic [31:0] b;
    case (r)
      VR_PARAM: b = REG_PARAM_BASE;
      VR_MAP:   b = REG_MAP_BASE;
      VR_TILE:  b = REG_TILE_BASE;
      VR_PAL:   b = REG_PAL_BASE;
      default:  b = 32'h0;
    endcase
    return b;
  endfunction

  // One-hot RAM strobe {PAL,TILE,MAP,PARAM}.
  function automatic logic [VRAM_NREG-1:0] vram_strobe(input vram_region_e r);
    logic [VRAM_NREG-1:0] oh;
    case (r)
      VR_PARAM: oh = 4'b0001;
      VR_MAP:   oh = 4'b0010;
      VR_TILE:  oh = 4'b0100;
      VR_PAL:   oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vram_shadow_fifo.sv
// Synchronous FIFO holding deferred PARAM writes; DEPTH must be a power of two.
module vram_shadow_fifo
  import gameconsole_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  shadow_entry_t wdata,
  output shadow_entry_t rdata_c,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  shadow_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_do_push;
  logic             w_do_pop;

  assign rdata_c = r_mem[r_rptr];

  // Accept a push on full only when a pop frees a slot in the same cycle.
  always_comb begin
    w_do_pop    = pop & ~empty;
    w_do_push   = push & (~full | w_do_pop);
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (w_do_pop && !w_do_push) w_count_nxt = r_count - CNT_W'(1);
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == CNT_W'(DEPTH));
      empty   <= (w_count_nxt == '0);
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/vram_bus_responder.sv
// CPU memory-port responder for the video RAMs: decodes requests into PARAM/MAP/TILE/PAL,
// drives a one-hot RAM strobe bus and returns read data at fixed latency.
// Define VRAM_SHADOW_EN to defer PARAM writes outside vblank through a shadow FIFO.
module vram_bus_responder
  import gameconsole_pkg::*;
#(
  parameter int unsigned OFS_W        = VRAM_OFS_W,
  parameter int unsigned RAM_RD_LAT   = 1,
  parameter int unsigned SHADOW_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vblank,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_din,
  output logic [31:0]           mem_dout,
  output logic                  mem_rvalid,
  output logic                  mem_err,
  output logic [3:0]            ram_we,
  output logic [3:0]            ram_re,
  output logic [OFS_W-1:0]      ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [3:0][31:0]      ram_rdata,
  output logic                  shadow_ovf
);

  vram_region_e     w_region;
  logic [3:0]       w_region_oh;
  logic [OFS_W-1:0] w_ofs;

  logic [3:0]       w_ram_we_d;
  logic [3:0]       w_ram_re_d;
  logic [OFS_W-1:0] w_ram_addr_d;
  logic [31:0]      w_ram_wdata_d;
  logic             w_err_d;
  logic             w_rd_v_d;
  vram_region_e     w_rd_reg_d;

  logic             r_s1_rd_v;
  vram_region_e     r_s1_rd_reg;
  logic             r_rd_v   [RAM_RD_LAT];
  vram_region_e     r_rd_reg [RAM_RD_LAT];
  vram_region_e     w_rd_tail;
  logic [1:0]       w_rd_idx;

  assign w_region    = vram_decode(mem_addr);
  assign w_region_oh = vram_strobe(w_region);
  assign w_ofs       = OFS_W'(mem_addr - vram_base(w_region));
  assign w_rd_tail   = r_rd_reg[RAM_RD_LAT-1];
  assign w_rd_idx    = w_rd_tail[1:0];

`ifdef VRAM_SHADOW_EN
  shadow_state_e r_state;
  shadow_state_e w_state_nxt;
  logic          r_shadow_ovf;
  logic          w_ovf_d;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_shadow_take;
  shadow_entry_t w_fifo_wdata;
  shadow_entry_t w_fifo_head;

  // Once anything is queued, later PARAM writes must queue behind it to keep order.
  assign w_shadow_take     = (w_region == VR_PARAM) && (!vblank || !w_fifo_empty);
  assign w_fifo_wdata.ofs  = VRAM_OFS_W'(w_ofs);
  assign w_fifo_wdata.data = mem_din;
  assign shadow_ovf        = r_shadow_ovf;

  vram_shadow_fifo #(
    .DEPTH (SHADOW_DEPTH)
  ) u_shadow_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   (w_fifo_wdata),
    .rdata_c (w_fifo_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // Drain state register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shadow_ovf <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow_ovf <= w_ovf_d;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{vblank, 1'(SHADOW_DEPTH)};
  assign shadow_ovf  = 1'b0;
`endif

  // Request decode, bus arbitration (CPU over drain) and drain next-state.
  always_comb begin
    w_ram_we_d    = '0;
    w_ram_re_d    = '0;
    w_ram_addr_d  = '0;
    w_ram_wdata_d = '0;
    w_err_d       = 1'b0;
    w_rd_v_d      = 1'b0;
    w_rd_reg_d    = VR_NONE;
`ifdef VRAM_SHADOW_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_ovf_d       = r_shadow_ovf;
    w_state_nxt   = r_state;
`endif
    if (mem_en) begin
      w_rd_v_d   = ~mem_we;
      w_rd_reg_d = w_region;
      if (w_region == VR_NONE) begin
        w_err_d = 1'b1;
      end
`ifdef VRAM_SHADOW_EN
      else if (mem_we && w_shadow_take) begin
        w_push = 1'b1;
        if (w_fifo_full) begin
          w_err_d = 1'b1;
          w_ovf_d = 1'b1;
        end
      end
`endif
      else begin
        if (mem_we) w_ram_we_d = w_region_oh;
        else        w_ram_re_d = w_region_oh;
        w_ram_addr_d  = w_ofs;
        w_ram_wdata_d = mem_we ? mem_din : 32'h0;
      end
    end
`ifdef VRAM_SHADOW_EN
    else if (r_state == ST_DRAIN && vblank && !w_fifo_empty) begin
      w_pop         = 1'b1;
      w_ram_we_d    = vram_strobe(VR_PARAM);
      w_ram_addr_d  = OFS_W'(w_fifo_head.ofs);
      w_ram_wdata_d = w_fifo_head.data;
    end

    case (r_state)
      ST_IDLE:  if (vblank && !w_fifo_empty) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vblank || w_fifo_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
`endif
  end

  // Single-cycle RAM strobe stage and unmapped/drop error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we    <= '0;
      ram_re    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      ram_we    <= w_ram_we_d;
      ram_re    <= w_ram_re_d;
      ram_addr  <= w_ram_addr_d;
      ram_wdata <= w_ram_wdata_d;
      mem_err   <= w_err_d;
    end
  end

  // Read tracking: follows each read through the RAM latency, then registers the return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_rd_v   <= 1'b0;
      r_s1_rd_reg <= VR_NONE;
      for (int k = 0; k < RAM_RD_LAT; k++) begin
        r_rd_v[k]   <= 1'b0;
        r_rd_reg[k] <= VR_NONE;
      end
      mem_rvalid <= 1'b0;
      mem_dout   <= '0;
    end else begin
      r_s1_rd_v   <= w_rd_v_d;
      r_s1_rd_reg <= w_rd_reg_d;
      r_rd_v[0]   <= r_s1_rd_v;
      r_rd_reg[0] <= r_s1_rd_reg;
      for (int k = 1; k < RAM_RD_LAT; k++) begin
        r_rd_v[k]   <= r_rd_v[k-1];
        r_rd_reg[k] <= r_rd_reg[k-1];
      end
      mem_rvalid <= r_rd_v[RAM_RD_LAT-1];
      mem_dout   <= (r_rd_v[RAM_RD_LAT-1] && w_rd_tail != VR_NONE) ? ram_rdata[w_rd_idx] : 32'h0;
    end
  end

endmodule
